prog_clock_divider: RTL and testbench

- Runtime-programmable clock divider. Successor to the fixed-ratio divider used in the alarm-clock timebase.
- The divide ratio is loaded at run time through a valid/ready handshake and takes effect glitch-free, only at a period boundary.
- Two output modes: a square-wave divided clock and a single-cycle tick (enable strobe).
- Used for the 1 Hz seconds base, the display-mux rate and the buzzer tone, all from one system clock.

---
 rtl/prog_clock_divider.sv | 101 ++++++++++
 tb/tb_prog_clock_divider.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider: square-wave or tick output, divisor
// loaded through a valid/ready handshake and applied only at period boundaries.
module prog_clock_divider #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             mode,
    input  logic [WIDTH-1:0] div_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             div_clk,
    output logic             tick,
    output logic [WIDTH-1:0] cur_div
);

    localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_D = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] pend;

    logic [WIDTH-1:0] count_nx;
    logic [WIDTH-1:0] pend_nx;
    logic [WIDTH-1:0] d_nx;
    logic [WIDTH-1:0] low_len;
    logic [WIDTH-1:0] clamped;
    logic             ready_nx;
    logic             div_clk_nx;
    logic             tick_nx;
    logic             xfer;
    logic             wrap;
    logic             apply;

    // Low phase is the longer half for odd divisors.
    assign low_len = cur_div - (cur_div >> 1);
    // Divisors below 2 cannot form a period; store them as 2.
    assign clamped = (div_in < MIN_D) ? MIN_D : div_in;

    // Next-state for counter, divisor slot and registered outputs.
    always_comb begin
        count_nx   = count;
        pend_nx    = pend;
        d_nx       = cur_div;
        ready_nx   = load_ready;
        div_clk_nx = div_clk;
        tick_nx    = 1'b0;

        xfer  = load_valid && load_ready;
        wrap  = en && (count == cur_div - ONE);
        // The slot is full exactly when load_ready is low.
        apply = !load_ready && (sync_clr || wrap || !en);

        if (sync_clr) begin
            count_nx   = '0;
            div_clk_nx = 1'b0;
        end else if (wrap) begin
            count_nx   = '0;
            tick_nx    = 1'b1;
            div_clk_nx = mode ? 1'b1 : (count >= low_len);
        end else if (en) begin
            count_nx   = count + ONE;
            div_clk_nx = mode ? 1'b0 : (count >= low_len);
        end

        if (apply) begin
            d_nx     = pend;
            ready_nx = 1'b1;
        end

        // A value captured now never lands in d this edge; it waits for the next boundary.
        if (xfer) begin
            pend_nx  = clamped;
            ready_nx = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count      <= '0;
            pend       <= DEF_D;
            cur_div    <= DEF_D;
            load_ready <= 1'b1;
            div_clk    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            count      <= count_nx;
            pend       <= pend_nx;
            cur_div    <= d_nx;
            load_ready <= ready_nx;
            div_clk    <= div_clk_nx;
            tick       <= tick_nx;
        end
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the divider.
module tb_prog_clock_divider;

    localparam int unsigned W   = 8;
    localparam int unsigned DEF = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         sync_clr;
    logic         mode;
    logic [W-1:0] div_in;
    logic         load_valid;
    logic         load_ready;
    logic         div_clk;
    logic         tick;
    logic [W-1:0] cur_div;

    prog_clock_divider #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sync_clr   (sync_clr),
        .mode       (mode),
        .div_in     (div_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .div_clk    (div_clk),
        .tick       (tick),
        .cur_div    (cur_div)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Behavioural model state: position in period, divisor, one-deep slot.
    int m_count = 0;
    int m_d     = DEF;
    int m_pend  = 0;
    bit m_full  = 1'b0;
    bit m_div   = 1'b0;
    bit m_tick  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        bit last;
        bit xfer;
        int new_d;
        if (!rst) begin
            m_count = 0; m_d = DEF; m_full = 1'b0; m_div = 1'b0; m_tick = 1'b0;
            return;
        end
        last  = en && (m_count == m_d - 1);
        xfer  = load_valid && !m_full;
        new_d = m_d;
        if (m_full && (sync_clr || last || !en)) begin
            new_d  = m_pend;
            m_full = 1'b0;
        end
        if (sync_clr) begin
            m_div = 1'b0; m_tick = 1'b0; m_count = 0;
        end else if (en) begin
            m_tick  = last;
            m_div   = mode ? last : (m_count >= m_d - m_d / 2);
            m_count = last ? 0 : (m_count + 1) % (1 << W);
        end else begin
            m_tick = 1'b0;
        end
        if (xfer) begin
            m_pend = (int'(div_in) < 2) ? 2 : int'(div_in);
            m_full = 1'b1;
        end
        m_d = new_d;
    endtask

    // One clock: model update at the edge, compare all outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("cur_div", int'(cur_div), m_d);
        check("load_ready", int'(load_ready), int'(!m_full));
        check("div_clk", int'(div_clk), int'(m_div));
        check("tick", int'(tick), int'(m_tick));
    endtask

    // Step until tick is seen; n is the number of edges taken.
    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < limit);
        if (!tick) check("tick_timeout", int'(tick), 1);
    endtask

    task automatic load(input int v);
        load_valid = 1'b1;
        div_in     = W'(v);
        step();
        load_valid = 1'b0;
    endtask

    int n;
    int pulses;
    bit dc[1:20];
    bit tk[1:20];

    initial begin
        rst = 1'b0; en = 1'b0; sync_clr = 1'b0; mode = 1'b0;
        div_in = '0; load_valid = 1'b0;
        step();
        check("rst_cur_div", int'(cur_div), 10);
        check("rst_ready", int'(load_ready), 1);
        check("rst_div_clk", int'(div_clk), 0);
        check("rst_tick", int'(tick), 0);

        // Square wave at the default divisor.
        rst = 1'b1; en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            dc[k] = div_clk;
            tk[k] = tick;
        end
        check("sq_low5", int'(dc[5]), 0);
        check("sq_high6", int'(dc[6]), 1);
        check("sq_high10", int'(dc[10]), 1);
        check("sq_low11", int'(dc[11]), 0);
        check("sq_tick9", int'(tk[9]), 0);
        check("sq_tick10", int'(tk[10]), 1);
        check("sq_tick20", int'(tk[20]), 1);

        // Load 7 mid-period: old period completes, then 7-cycle periods.
        step(); step(); step();
        load(7);
        check("ld7_ready_low", int'(load_ready), 0);
        check("ld7_still10", int'(cur_div), 10);
        wait_tick(20, n);
        check("ld7_rest_of_10", n, 6);
        check("ld7_applied", int'(cur_div), 7);
        check("ld7_ready_back", int'(load_ready), 1);
        wait_tick(20, n);
        check("ld7_period", n, 7);

        // Loads of 1 and 0 clamp to 2.
        load(1);
        wait_tick(20, n);
        check("clamp1", int'(cur_div), 2);
        step();
        check("d2_dc0", int'(div_clk), 0);
        check("d2_tk0", int'(tick), 0);
        step();
        check("d2_dc1", int'(div_clk), 1);
        check("d2_tk1", int'(tick), 1);
        load(0);
        wait_tick(20, n);
        check("clamp0", int'(cur_div), 2);

        // Tick mode, D=4, enable dropped for 3 cycles mid-stream.
        mode = 1'b1;
        load(4);
        wait_tick(20, n);
        check("m1_d4", int'(cur_div), 4);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            en = !(i >= 6 && i < 9);
            step();
            if (!en) check("m1_hold_tick", int'(tick), 0);
            pulses += int'(tick);
        end
        en = 1'b1;
        check("m1_pulses", pulses, 3);

        // sync_clr with a pending value, then a transfer coinciding with sync_clr.
        mode = 1'b0;
        load(9);
        wait_tick(30, n);
        load(12);
        n = 0;
        while (m_count != 6 && n < 30) begin step(); n++; end
        check("reach_count6", m_count, 6);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check("sc_cur_div", int'(cur_div), 12);
        check("sc_div_clk", int'(div_clk), 0);
        check("sc_tick", int'(tick), 0);
        check("sc_ready", int'(load_ready), 1);
        sync_clr = 1'b1;
        load(5);
        sync_clr = 1'b0;
        check("sc_xfer_d", int'(cur_div), 12);
        check("sc_xfer_ready", int'(load_ready), 0);
        step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check("sc_xfer_applied", int'(cur_div), 5);

        // Reset mid-period discards pending; reset beats sync_clr.
        load(20);
        step(); step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mrst_cur_div", int'(cur_div), 10);
        check("mrst_ready", int'(load_ready), 1);
        check("mrst_div_clk", int'(div_clk), 0);
        check("mrst_tick", int'(tick), 0);
        step(); step();
        load(3);
        rst = 1'b0; sync_clr = 1'b1;
        step();
        rst = 1'b1; sync_clr = 1'b0;
        check("rst_over_sc_d", int'(cur_div), 10);
        check("rst_over_sc_ready", int'(load_ready), 1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 399) != 0);
            en         = ($urandom_range(0, 99) < 85);
            sync_clr   = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 2) mode = ~mode;
            load_valid = ($urandom_range(0, 99) < 20);
            div_in     = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 15));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
